// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared constants and types for the MAC-array datapath: lane count, partial
// sum width, buffer depth, the row/destination address width used by both the
// controller and the output accumulation buffer, and the buffer FSM states.
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int LANES  = 4;
    localparam int ACC_W  = 20;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int ROW_W  = LANES * ACC_W;

    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Assemble a row from individual lanes; lane 0 sits in the low bits.
    function automatic row_t pack_row(input logic [ACC_W-1:0] l0,
                                      input logic [ACC_W-1:0] l1,
                                      input logic [ACC_W-1:0] l2,
                                      input logic [ACC_W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/oacc_lane.sv
// ---------------------------------------------------------------------------
// oacc_lane
// One lane of the output accumulation datapath: chooses the stored operand
// (forwarded in-flight result or value read from memory), then either
// overwrites it with the incoming partial sum or adds the two.
//
// Build option: OUT_SAT_EN -- when defined the add saturates to the signed
// ACC_W range and reports saturation on sat; otherwise it wraps and the sat
// port does not exist.
//
// Ports
//   acc       in   1      1 = accumulate, 0 = overwrite
//   in_data   in   ACC_W  incoming signed partial sum
//   mem_data  in   ACC_W  stored value read from the buffer
//   fwd_en    in   1      use fwd_data instead of mem_data
//   fwd_data  in   ACC_W  result of the previous row still in flight
//   res       out  ACC_W  value to write back
//   sat       out  1      saturation occurred (OUT_SAT_EN only)
// ---------------------------------------------------------------------------
module oacc_lane
    import mac_pkg::*;
(
    input  logic             acc,
    input  logic [ACC_W-1:0] in_data,
    input  logic [ACC_W-1:0] mem_data,
    input  logic             fwd_en,
    input  logic [ACC_W-1:0] fwd_data,
    output logic [ACC_W-1:0] res
`ifdef OUT_SAT_EN
    ,
    output logic             sat
`endif
);

    logic [ACC_W-1:0] base;

    assign base = fwd_en ? fwd_data : mem_data;

`ifdef OUT_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_full;

    always_comb begin
        sum_full = {base[ACC_W-1], base} + {in_data[ACC_W-1], in_data};
        sat      = 1'b0;
        res      = in_data;
        if (acc) begin
            // Top two bits disagree only when the signed result left range.
            if (sum_full[ACC_W] != sum_full[ACC_W-1]) begin
                sat = 1'b1;
                res = sum_full[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                res = sum_full[ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        res = acc ? (base + in_data) : in_data;
    end
`endif

endmodule

// File: rtl/out_accum_buf.sv
// ---------------------------------------------------------------------------
// out_accum_buf
// Output accumulation buffer behind the MAC-array controller. Rows of LANES
// signed partial sums are written to row ODst, either overwriting or adding
// to the stored row, then the finished DEPTH x LANES result is read out by
// the host side.
//
// Pipeline: S1 registers the incoming row and the stored operand, S2
// registers the computed result, which is written to memory the next edge.
// Two forwarding points keep full rate with no stalls: the S1 read takes the
// S2 result if that row is being written in the same cycle, and the S2
// compute takes the S2 result when the previous row targets the same ODst.
//
// Build option: OUT_SAT_EN -- saturating lane adds and sticky Ovf flag;
// when undefined adds wrap and Ovf is constant 0.
//
// Ports
//   CLK      in   1      clock, rising edge
//   RST      in   1      asynchronous active-high reset
//   Clear    in   1      zero all rows, then accept rows (ACCUM)
//   InValid  in   1      input row valid
//   InReady  out  1      row accepted this cycle when InValid
//   InData   in   ROW_W  lane k at [k*ACC_W +: ACC_W]
//   ODst     in   4      destination row
//   Acc      in   1      1 = add to stored row, 0 = overwrite
//   Last     in   1      final row of the operation
//   Done     out  1      one-cycle pulse after the Last row is written
//   RdEn     in   1      read request (IDLE/DONE only)
//   RdAddr   in   4      read row
//   RdValid  out  1      RdData valid, one cycle after RdEn
//   RdData   out  ROW_W  read row, holds between reads
//   Busy     out  1      high in CLEAR and ACCUM
//   Ovf      out  1      sticky saturation flag
// ---------------------------------------------------------------------------
module out_accum_buf
    import mac_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Clear,
    input  logic              InValid,
    output logic              InReady,
    input  logic [ROW_W-1:0]  InData,
    input  logic [ADDR_W-1:0] ODst,
    input  logic              Acc,
    input  logic              Last,
    output logic              Done,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic              RdValid,
    output logic [ROW_W-1:0]  RdData,
    output logic              Busy,
    output logic              Ovf
);

    state_t state;
    addr_t  clr_addr;
    logic   last_pend;

    row_t   mem [DEPTH];

    logic   s1_valid;
    logic   s1_acc;
    logic   s1_last;
    addr_t  s1_dst;
    row_t   s1_data;
    row_t   s1_mem;

    logic   s2_valid;
    logic   s2_last;
    addr_t  s2_dst;
    row_t   s2_res;

    logic   wb_last;

    logic   accept;
    logic   fwd_s1;
    logic   fwd_s2;
    row_t   lane_res;

    assign InReady = (state == ACCUM) && !last_pend;
    assign accept  = InValid && InReady && !Clear;
    assign fwd_s1  = s2_valid && (s2_dst == ODst);
    assign fwd_s2  = s2_valid && (s2_dst == s1_dst);

`ifdef OUT_SAT_EN
    logic [LANES-1:0] lane_sat;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        oacc_lane u_lane (
            .acc      (s1_acc),
            .in_data  (s1_data[k*ACC_W +: ACC_W]),
            .mem_data (s1_mem[k*ACC_W +: ACC_W]),
            .fwd_en   (fwd_s2),
            .fwd_data (s2_res[k*ACC_W +: ACC_W]),
            .res      (lane_res[k*ACC_W +: ACC_W])
`ifdef OUT_SAT_EN
            ,
            .sat      (lane_sat[k])
`endif
        );
    end

    // Row storage: the clear walk and the S2 write-back never overlap, since
    // Clear flushes the pipeline. A write-back coinciding with Clear is dropped.
    always_ff @(posedge CLK) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (s2_valid && !Clear) begin
            mem[s2_dst] <= s2_res;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            clr_addr  <= '0;
            last_pend <= 1'b0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
            RdValid   <= 1'b0;
            RdData    <= '0;
            s1_valid  <= 1'b0;
            s1_acc    <= 1'b0;
            s1_last   <= 1'b0;
            s1_dst    <= '0;
            s1_data   <= '0;
            s1_mem    <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_dst    <= '0;
            s2_res    <= '0;
            wb_last   <= 1'b0;
        end else begin
            Done    <= 1'b0;
            RdValid <= 1'b0;

            // S1: capture row and stored operand.
            s1_valid <= accept;
            if (accept) begin
                s1_acc  <= Acc;
                s1_last <= Last;
                s1_dst  <= ODst;
                s1_data <= InData;
                s1_mem  <= fwd_s1 ? s2_res : mem[ODst];
            end

            // S2: register the lane results for write-back.
            s2_valid <= s1_valid && !Clear;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_dst  <= s1_dst;
                s2_res  <= lane_res;
            end

            wb_last <= s2_valid && s2_last && !Clear;

            if (Clear) begin
                state     <= CLEAR;
                clr_addr  <= '0;
                last_pend <= 1'b0;
                Busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (RdEn) begin
                            RdData  <= mem[RdAddr];
                            RdValid <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (accept && Last) begin
                            last_pend <= 1'b1;
                        end
                        if (wb_last) begin
                            state     <= DONE;
                            Done      <= 1'b1;
                            Busy      <= 1'b0;
                            last_pend <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        if (RdEn) begin
                            RdData  <= mem[RdAddr];
                            RdValid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef OUT_SAT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Ovf <= 1'b0;
        end else if (Clear) begin
            Ovf <= 1'b0;
        end else if (s1_valid && (|lane_sat)) begin
            Ovf <= 1'b1;
        end
    end
`else
    assign Ovf = 1'b0;
`endif

endmodule
